// File: rtl/ex_mem_stage_pkg.sv
// Shared widths, constants and encodings for the pipeline-boundary stages.
// The active-low reset level is defined once here for this block and its successors.
package ex_mem_stage_pkg;

  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_BUS_W-1:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic                 RST_ASSERT = 1'b0;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/stage_skid_buf.sv
// Generic two-entry valid/ready skid buffer: main entry is the head, skid absorbs
// one extra push after back-pressure so in_ready can come straight from a flop.
module stage_skid_buf
  import ex_mem_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  skid_state_t  state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         push;
  logic         pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;

  always_comb begin
    occ = OCC_EMPTY;
    case (state)
      ST_ONE:  occ = OCC_ONE;
      ST_TWO:  occ = OCC_TWO;
      default: occ = OCC_EMPTY;
    endcase
  end

  // Payloads of invalid entries are kept at zero; in_ready tracks "next state is not full".
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ASSERT) begin
      state    <= ST_EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      in_ready <= 1'b1;
    end else if (flush) begin
      state    <= ST_EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      in_ready <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            state  <= ST_ONE;
            main_q <= in_data;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            state    <= ST_TWO;
            skid_q   <= in_data;
            in_ready <= 1'b0;
          end else if (push && pop) begin
            main_q <= in_data;
          end else if (pop) begin
            state  <= ST_EMPTY;
            main_q <= '0;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state    <= ST_ONE;
            main_q   <= skid_q;
            skid_q   <= '0;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= ST_EMPTY;
          main_q   <= '0;
          skid_q   <= '0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: skid buffer carrying {wd, wreg, wdata}, with bubble
// gating on the memory-side outputs and an occupancy report for the hazard unit.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [ADDR_W-1:0] ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              flush_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_wd_o,
  output logic              mem_wreg_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [1:0]        occ_o
);

  localparam int PW = ADDR_W + 1 + DATA_W;
  localparam logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(ZERO_WORD);

  logic [PW-1:0]     head;
  logic [ADDR_W-1:0] head_wd;
  logic              head_wreg;
  logic [DATA_W-1:0] head_wdata;

  stage_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (ex_valid_i),
    .in_ready  (ex_ready_o),
    .in_data   ({ex_wd_i, ex_wreg_i, ex_wdata_i}),
    .flush     (flush_i),
    .out_valid (mem_valid_o),
    .out_ready (mem_ready_i),
    .out_data  (head),
    .occ       (occ_o)
  );

  assign {head_wd, head_wreg, head_wdata} = head;

  // A bubble must never look like a GPR write, whatever the head registers hold.
  assign mem_wd_o    = mem_valid_o ? head_wd    : '0;
  assign mem_wreg_o  = mem_valid_o & head_wreg;
  assign mem_wdata_o = mem_valid_o ? head_wdata : BUBBLE_DATA;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [4:0]  ex_wd_i = '0;
  logic        ex_wreg_i = 1'b0;
  logic [31:0] ex_wdata_i = '0;
  logic        flush_i = 1'b0;
  logic        mem_valid_o;
  logic        mem_ready_i = 1'b0;
  logic [4:0]  mem_wd_o;
  logic        mem_wreg_o;
  logic [31:0] mem_wdata_o;
  logic [1:0]  occ_o;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } entry_t;

  entry_t model_q[$];
  bit     exp_ready = 1'b1;
  bit     check_en  = 1'b0;
  int     n_tests   = 0;
  int     n_fail    = 0;

  ex_mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid_i  (ex_valid_i),
    .ex_ready_o  (ex_ready_o),
    .ex_wd_i     (ex_wd_i),
    .ex_wreg_i   (ex_wreg_i),
    .ex_wdata_i  (ex_wdata_i),
    .flush_i     (flush_i),
    .mem_valid_o (mem_valid_o),
    .mem_ready_i (mem_ready_i),
    .mem_wd_o    (mem_wd_o),
    .mem_wreg_o  (mem_wreg_o),
    .mem_wdata_o (mem_wdata_o),
    .occ_o       (occ_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] wd, input logic wreg,
                               input logic [31:0] wdata, input logic mrdy, input logic fl);
    ex_valid_i  = v;
    ex_wd_i     = wd;
    ex_wreg_i   = wreg;
    ex_wdata_i  = wdata;
    mem_ready_i = mrdy;
    flush_i     = fl;
    @(negedge clk);
  endtask

  // Reference: an in-order FIFO of capacity two; acceptance means fewer than two held.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_q.delete();
      exp_ready = 1'b1;
    end else begin
      bit     m_push;
      bit     m_pop;
      entry_t e;
      m_push = ex_valid_i && exp_ready;
      m_pop  = (model_q.size() > 0) && mem_ready_i;
      if (flush_i) begin
        model_q.delete();
      end else begin
        if (m_pop) void'(model_q.pop_front());
        if (m_push) begin
          e.wd    = ex_wd_i;
          e.wreg  = ex_wreg_i;
          e.wdata = ex_wdata_i;
          model_q.push_back(e);
        end
      end
      exp_ready = (model_q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic        ev;
      logic [4:0]  ewd;
      logic        ewreg;
      logic [31:0] ewdata;
      ev = 1'b0; ewd = '0; ewreg = 1'b0; ewdata = '0;
      if (model_q.size() > 0) begin
        ev     = 1'b1;
        ewd    = model_q[0].wd;
        ewreg  = model_q[0].wreg;
        ewdata = model_q[0].wdata;
      end
      checkOutput("cmp_valid", mem_valid_o, ev);
      checkOutput("cmp_ready", ex_ready_o, exp_ready);
      checkOutput("cmp_occ",   occ_o, model_q.size());
      checkOutput("cmp_wd",    mem_wd_o, ewd);
      checkOutput("cmp_wreg",  mem_wreg_o, ewreg);
      checkOutput("cmp_wdata", mem_wdata_o, ewdata);
    end
  end

  initial begin
    #1 rst = 1'b0;
    check_en = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", mem_valid_o, 0);
    checkOutput("rst_ready", ex_ready_o, 1);
    checkOutput("rst_occ",   occ_o, 0);
    checkOutput("rst_wreg",  mem_wreg_o, 0);
    checkOutput("rst_wdata", mem_wdata_o, 0);
    rst = 1'b1;

    // Single push, then drain.
    applyStimulus(1, 5'd5, 1, 32'h0000_1234, 1, 0);
    checkOutput("single_valid", mem_valid_o, 1);
    checkOutput("single_wd",    mem_wd_o, 5);
    checkOutput("single_wreg",  mem_wreg_o, 1);
    checkOutput("single_wdata", mem_wdata_o, 32'h1234);
    checkOutput("single_occ",   occ_o, 1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("single_drain_occ", occ_o, 0);

    // Back-pressure fill, ignored push while full, ordered drain.
    applyStimulus(1, 5'd1, 1, 32'hA, 0, 0);
    applyStimulus(1, 5'd2, 1, 32'hB, 0, 0);
    checkOutput("bp_occ",   occ_o, 2);
    checkOutput("bp_ready", ex_ready_o, 0);
    checkOutput("bp_headA", mem_wdata_o, 32'hA);
    applyStimulus(1, 5'd3, 1, 32'hDEAD, 0, 0);
    checkOutput("bp_ignored_occ", occ_o, 2);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("bp_headB",   mem_wdata_o, 32'hB);
    checkOutput("bp_occ1",    occ_o, 1);
    checkOutput("bp_ready1",  ex_ready_o, 1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("bp_empty", occ_o, 0);

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 5'(i), 1, 32'(i), 1, 0);
      checkOutput("stream_data", mem_wdata_o, i);
      checkOutput("stream_occ",  occ_o, 1);
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("stream_empty", occ_o, 0);

    // Flush while full with a push attempt.
    applyStimulus(1, 5'd1, 1, 32'hA, 0, 0);
    applyStimulus(1, 5'd2, 1, 32'hB, 0, 0);
    applyStimulus(1, 5'd4, 1, 32'hC, 0, 1);
    checkOutput("flush_occ",   occ_o, 0);
    checkOutput("flush_valid", mem_valid_o, 0);
    checkOutput("flush_wreg",  mem_wreg_o, 0);
    checkOutput("flush_ready", ex_ready_o, 1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("flush_noC", mem_valid_o, 0);

    // Flush from one entry while the stage is accepting: the push is dropped.
    applyStimulus(1, 5'd6, 1, 32'h66, 0, 0);
    applyStimulus(1, 5'd7, 1, 32'hE, 1, 1);
    checkOutput("flush1_valid", mem_valid_o, 0);
    checkOutput("flush1_wdata", mem_wdata_o, 0);
    checkOutput("flush1_occ",   occ_o, 0);

    // wreg=0 instruction still flows and is counted.
    applyStimulus(1, 5'd7, 0, 32'h55, 0, 0);
    checkOutput("nowreg_valid", mem_valid_o, 1);
    checkOutput("nowreg_wd",    mem_wd_o, 7);
    checkOutput("nowreg_wreg",  mem_wreg_o, 0);
    checkOutput("nowreg_wdata", mem_wdata_o, 32'h55);
    checkOutput("nowreg_occ",   occ_o, 1);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Asynchronous reset between edges while full.
    applyStimulus(1, 5'd1, 1, 32'h11, 0, 0);
    applyStimulus(1, 5'd2, 1, 32'h22, 0, 0);
    ex_valid_i = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_valid", mem_valid_o, 0);
    checkOutput("arst_occ",   occ_o, 0);
    checkOutput("arst_ready", ex_ready_o, 1);
    checkOutput("arst_wdata", mem_wdata_o, 0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("arst_after_valid", mem_valid_o, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("arst_after_occ", occ_o, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom), $urandom,
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline boundary between the execute stage and the memory-access stage.
- Captures the execute result triple (destination GPR address, write-enable, write data) under a valid/ready handshake.
- A one-entry skid buffer lets the execute stage retire one extra instruction after memory-side back-pressure appears, so the ready path stays registered.
- Also supports a synchronous flush for branch/exception squash, and reports occupancy to the hazard unit.

Parameters:
- DATA_W, 32, width of the write-data word (matches the GPR width).
- ADDR_W, 5, width of the destination GPR address.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid_i  in  1  execute stage presents a result this cycle.
- ex_ready_o  out  1  this block can accept a result this cycle; registered output.
- ex_wd_i  in  ADDR_W  destination GPR address from execute.
- ex_wreg_i  in  1  GPR write-enable from execute.
- ex_wdata_i  in  DATA_W  result word from execute.
- flush_i  in  1  squash all held entries at the next edge.
- mem_valid_o  out  1  head entry is valid.
- mem_ready_i  in  1  memory stage consumes the head entry this cycle.
- mem_wd_o  out  ADDR_W  head destination address.
- mem_wreg_o  out  1  head write-enable, gated by mem_valid_o.
- mem_wdata_o  out  DATA_W  head result word.
- occ_o  out  2  number of held entries (0, 1 or 2).

Behaviour:
- Storage: a main entry (head, drives mem_*) and a skid entry. Each has a valid bit, wd, wreg and wdata.
- States:
  - EMPTY: no entries valid.
  - ONE: main valid, skid empty.
  - TWO: both valid.
  - occ_o encodes the state as 0, 1 or 2.
- Handshake definitions:
  - push = ex_valid_i & ex_ready_o.
  - pop = mem_valid_o & mem_ready_i.
  - Payload transfers only on push. Inputs are ignored when ex_ready_o=0.
- ex_ready_o is the registered value of (next state != TWO).
- mem_valid_o = main valid.
- Transitions (when flush_i=0):
  - EMPTY + push -> ONE; payload into main.
  - ONE + push + !pop -> TWO; payload into skid.
  - ONE + push + pop -> ONE; main overwritten with the new payload.
  - ONE + !push + pop -> EMPTY.
  - TWO + pop -> ONE; skid moves to main, skid cleared. push is impossible in TWO because ex_ready_o=0.
  - Any other combination -> hold.
- Latency: 1 cycle from push to mem_valid_o.
- Ordering: entries leave strictly in arrival order.
- Entries with wreg=0 are still valid instructions and flow normally.
- Bubble outputs: while mem_valid_o=0, mem_wreg_o=0, mem_wd_o=0 and mem_wdata_o=0. An empty stage can never write a GPR.
- Flush:
  - flush_i=1 at an edge -> state EMPTY, both valid bits cleared, ex_ready_o=1 next cycle.
  - A simultaneous push is dropped, not captured.
  - A simultaneous pop still counts as a completed handshake for the memory stage; flush has no retroactive effect on it.
- Reset:
  - rst=0 asynchronously forces EMPTY and clears all payload registers.
  - Output values during and after reset: mem_valid_o=0, mem_wreg_o=0, mem_wd_o=0, mem_wdata_o=0, occ_o=0, ex_ready_o=1.
  - Reset asserted mid-transfer discards both entries.
- Payload registers of invalid entries are zeroed, so outputs are deterministic.
- No X propagation: unknown ex_* payload is never captured while ex_valid_i=0.

Decomposition:
- Shared defines file holds:
  - the register-bus and register-address-bus widths;
  - the zero-word constant;
  - a new active-low reset-asserted constant (1'b0) for this block and its successors;
  - the 2-bit occupancy encodings OCC_EMPTY, OCC_ONE, OCC_TWO.
- One natural sub-module, stage_skid_buf: a generic two-entry valid/ready skid buffer with payload width as a parameter.
  - ex_mem_stage instantiates it with payload {wd, wreg, wdata}.
  - ex_mem_stage adds the output gating and occ_o.
  - The same sub-module is reusable for the mem/wb boundary.

Test Plan:
- Reset then single push: rst low 3 cycles, release; push wd=5, wreg=1, wdata=32'h0000_1234 with mem_ready_i=1 -> next cycle mem_valid_o=1, mem_wd_o=5, mem_wdata_o=32'h1234, occ_o=1; the cycle after, occ_o=0.
- Back-pressure fill: mem_ready_i=0, push A=32'hA, B=32'hB on consecutive cycles -> occ_o=2, ex_ready_o=0 after B; further ex_valid_i ignored. Raise mem_ready_i -> A then B emerge on successive cycles, ex_ready_o=1 one cycle after the first pop.
- Streaming: mem_ready_i=1, push 8 consecutive words 1..8 -> occ_o stays 1 and outputs 1..8 appear on 8 consecutive cycles, in order, none lost.
- Flush with simultaneous push: occ_o=2, assert flush_i plus ex_valid_i with wdata=32'hC -> next cycle occ_o=0, mem_valid_o=0, mem_wreg_o=0, ex_ready_o=1; 32'hC never appears.
- Async reset mid-operation: occ_o=2, drop rst between clock edges -> outputs reach reset values immediately without waiting for clk; held entries are never emitted after release.
- wreg=0 instruction: push wd=7, wreg=0, wdata=32'h55 -> mem_valid_o=1, mem_wreg_o=0, mem_wdata_o=32'h55; occupancy is counted normally.
